// File: rtl/mlp_pkg.sv
// Shared definitions for the small 2-8-3 MLP datapath: layer sizes, the pass
// sequencer states and the class-index type used by both forward and backward passes.
package mlp_pkg;

    localparam int NIN  = 2;
    localparam int NHID = 8;
    localparam int NOUT = 3;

    typedef enum logic [2:0] {
        IDLE,
        HID,
        OUT,
        ARG,
        DONE
    } state_t;

    typedef logic [1:0] idx_t;

endpackage

// File: rtl/forwardprop_mac_sat.sv
// Combinational fixed-point multiply-accumulate step: signed product, FRACBITS
// arithmetic shift, accumulate, plus saturation to the accumulator and data widths.
module mac_sat #(
    parameter int DATAWIDTH = 16,
    parameter int FRACBITS  = 8,
    parameter int ACCW      = DATAWIDTH + 4
) (
    input  logic signed [DATAWIDTH-1:0] i_a,
    input  logic signed [DATAWIDTH-1:0] i_b,
    input  logic signed [ACCW-1:0]      i_accIn,
    output logic signed [ACCW-1:0]      o_accOut,
    output logic signed [DATAWIDTH-1:0] o_sat
);

    localparam int PW = 2 * DATAWIDTH;
    localparam int SW = PW + 2;

    logic signed [PW-1:0]        w_prod;
    logic signed [PW-1:0]        w_shifted;
    logic signed [SW-1:0]        w_sum;
    logic [SW-ACCW:0]            w_sumTop;
    logic [ACCW-DATAWIDTH:0]     w_accTop;

    assign w_prod    = PW'(i_a) * PW'(i_b);
    assign w_shifted = w_prod >>> FRACBITS;
    assign w_sum     = SW'(w_shifted) + SW'(i_accIn);

    // The accumulator clamps at its own width instead of wrapping, so a huge
    // product can never fold back into range and escape write-back saturation.
    assign w_sumTop = w_sum[SW-1:ACCW-1];
    assign o_accOut = ((&w_sumTop) || (~(|w_sumTop))) ? w_sum[ACCW-1:0]
                    : {w_sum[SW-1], {(ACCW-1){~w_sum[SW-1]}}};

    assign w_accTop = o_accOut[ACCW-1:DATAWIDTH-1];
    assign o_sat    = ((&w_accTop) || (~(|w_accTop))) ? o_accOut[DATAWIDTH-1:0]
                    : {o_accOut[ACCW-1], {(DATAWIDTH-1){~o_accOut[ACCW-1]}}};

endmodule

// File: rtl/forwardprop.sv
// Forward pass of a 2-8-3 MLP using one time-shared MAC: relu hidden layer,
// linear output layer, then argmax; results are published together on DONE.
module forwardprop
    import mlp_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int FRACBITS  = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [NIN-1:0][DATAWIDTH-1:0]            inputs,
    input  logic [NHID-1:0][NIN-1:0][DATAWIDTH-1:0]  currW0,
    input  logic [NHID-1:0][DATAWIDTH-1:0]           currb0,
    input  logic [NOUT-1:0][NHID-1:0][DATAWIDTH-1:0] currW1,
    input  logic [NOUT-1:0][DATAWIDTH-1:0]           currb1,
    output logic                                     busy,
    output logic                                     done,
    output logic [NHID-1:0][DATAWIDTH-1:0]           reluout,
    output logic [NOUT-1:0][DATAWIDTH-1:0]           logits,
    output idx_t                                     predictedstate
);

    localparam int ACCW    = DATAWIDTH + 4;
    localparam int HIDLAST = NIN * NHID - 1;
    localparam int OUTLAST = NHID * NOUT - 1;

    state_t                         r_state;
    state_t                         w_nextState;
    logic [4:0]                     r_cnt;
    logic [NIN-1:0][DATAWIDTH-1:0]  r_x;
    logic [NHID-1:0][DATAWIDTH-1:0] r_a0;
    logic [NOUT-1:0][DATAWIDTH-1:0] r_z1;
    logic signed [ACCW-1:0]         r_acc;

    logic [2:0]                     w_hid;
    logic                           w_phase;
    logic [1:0]                     w_out;
    logic [2:0]                     w_j;
    logic signed [DATAWIDTH-1:0]    w_a;
    logic signed [DATAWIDTH-1:0]    w_b;
    logic signed [DATAWIDTH-1:0]    w_sat;
    logic signed [ACCW-1:0]         w_accIn;
    logic signed [ACCW-1:0]         w_accOut;
    idx_t                           w_argmax;

    // r_cnt doubles as the neuron/term index inside HID and OUT
    assign w_hid   = r_cnt[3:1];
    assign w_phase = r_cnt[0];
    assign w_out   = r_cnt[4:3];
    assign w_j     = r_cnt[2:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = HID;
            HID:     if (r_cnt == 5'(HIDLAST)) w_nextState = OUT;
            OUT:     if (r_cnt == 5'(OUTLAST)) w_nextState = ARG;
            ARG:     w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == HID) || (r_state == OUT) || (r_state == ARG);
        done = (r_state == DONE);
    end

    // The first term of every neuron seeds the accumulator with its bias
    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_accIn = r_acc;
        case (r_state)
            HID: begin
                w_a = currW0[w_hid][w_phase];
                w_b = r_x[w_phase];
                if (!w_phase) w_accIn = ACCW'($signed(currb0[w_hid]));
            end
            OUT: begin
                w_a = currW1[w_out][w_j];
                w_b = r_a0[w_j];
                if (w_j == 3'd0) w_accIn = ACCW'($signed(currb1[w_out]));
            end
            default: ;
        endcase
    end

    mac_sat #(
        .DATAWIDTH (DATAWIDTH),
        .FRACBITS  (FRACBITS),
        .ACCW      (ACCW)
    ) u_mac (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_accIn  (w_accIn),
        .o_accOut (w_accOut),
        .o_sat    (w_sat)
    );

    // Strict greater-than keeps ties on the lowest index
    always_comb begin
        w_argmax = '0;
        for (int i = 1; i < NOUT; i++) begin
            if ($signed(r_z1[i]) > $signed(r_z1[w_argmax])) w_argmax = idx_t'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_x            <= '0;
            r_a0           <= '0;
            r_z1           <= '0;
            r_acc          <= '0;
            reluout        <= '0;
            logits         <= '0;
            predictedstate <= '0;
        end else begin
            r_cnt <= (w_nextState != r_state) ? 5'd0 : r_cnt + 5'd1;
            case (r_state)
                IDLE: if (start) r_x <= inputs;
                HID: begin
                    r_acc <= w_accOut;
                    if (w_phase) r_a0[w_hid] <= w_sat[DATAWIDTH-1] ? '0 : w_sat;
                end
                OUT: begin
                    r_acc <= w_accOut;
                    if (w_j == 3'(NHID - 1)) r_z1[w_out] <= w_sat;
                end
                // Publish everything at once so observers never see a half-done pass
                ARG: begin
                    reluout        <= r_a0;
                    logits         <= r_z1;
                    predictedstate <= w_argmax;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_forwardprop.sv
// Self-checking bench for forwardprop: directed vectors plus randomized passes
// compared against an integer reference model of the network.
module tb_forwardprop;
    import mlp_pkg::*;

    localparam int DW    = 16;
    localparam int FB    = 8;
    localparam int LIMIT = 120;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [NIN-1:0][DW-1:0]            inputs;
    logic [NHID-1:0][NIN-1:0][DW-1:0]  currW0;
    logic [NHID-1:0][DW-1:0]           currb0;
    logic [NOUT-1:0][NHID-1:0][DW-1:0] currW1;
    logic [NOUT-1:0][DW-1:0]           currb1;
    logic                              busy;
    logic                              done;
    logic [NHID-1:0][DW-1:0]           reluout;
    logic [NOUT-1:0][DW-1:0]           logits;
    logic [1:0]                        predictedstate;

    int checks = 0;
    int errors = 0;

    logic [NIN-1:0][DW-1:0]  modelX;
    logic [NHID-1:0][DW-1:0] expRelu;
    logic [NOUT-1:0][DW-1:0] expLogits;
    logic [1:0]              expPred;

    forwardprop #(.DATAWIDTH(DW), .FRACBITS(FB)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .inputs         (inputs),
        .currW0         (currW0),
        .currb0         (currb0),
        .currW1         (currW1),
        .currb1         (currb1),
        .busy           (busy),
        .done           (done),
        .reluout        (reluout),
        .logits         (logits),
        .predictedstate (predictedstate)
    );

    always #5 clk = ~clk;

    function automatic longint clampBits(longint v, int bits);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [15:0] randVal();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 1023) - 512);
    endfunction

    // Reference network: exact integer arithmetic with floor-shifted products
    task automatic buildModel();
        longint acc;
        longint act [NHID];
        longint zs [NOUT];
        int best;
        for (int h = 0; h < NHID; h++) begin
            acc = longint'($signed(currb0[h]));
            for (int j = 0; j < NIN; j++)
                acc = clampBits(acc + ((longint'($signed(currW0[h][j])) * longint'($signed(modelX[j]))) >>> FB), DW + 4);
            acc = clampBits(acc, DW);
            act[h] = (acc < 0) ? 0 : acc;
            expRelu[h] = 16'(act[h]);
        end
        for (int o = 0; o < NOUT; o++) begin
            acc = longint'($signed(currb1[o]));
            for (int j = 0; j < NHID; j++)
                acc = clampBits(acc + ((longint'($signed(currW1[o][j])) * act[j]) >>> FB), DW + 4);
            zs[o] = clampBits(acc, DW);
            expLogits[o] = 16'(zs[o]);
        end
        best = 0;
        for (int o = 1; o < NOUT; o++) if (zs[o] > zs[best]) best = o;
        expPred = 2'(best);
    endtask

    task automatic applyStimulus();
        for (int j = 0; j < NIN; j++) inputs[j] = randVal();
        for (int h = 0; h < NHID; h++) begin
            currb0[h] = randVal();
            for (int j = 0; j < NIN; j++) currW0[h][j] = randVal();
        end
        for (int o = 0; o < NOUT; o++) begin
            currb1[o] = randVal();
            for (int j = 0; j < NHID; j++) currW1[o][j] = randVal();
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start  = 1'b1;
        modelX = inputs;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        inputs = '0; currW0 = '0; currb0 = '0; currW1 = '0; currb1 = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (reluout !== '0) begin errors++; $display("[TB] FAIL reset_reluout: got %h expected 0", reluout); end
        checks++; if (logits !== '0) begin errors++; $display("[TB] FAIL reset_logits: got %h expected 0", logits); end
        checks++; if (predictedstate !== 2'd0) begin errors++; $display("[TB] FAIL reset_pred: got %0d expected 0", predictedstate); end
        rst = 1'b0;
    endtask

    task automatic test_directed_latency();
        logic [NOUT-1:0][DW-1:0] expL;
        inputs[0] = 16'd256;
        inputs[1] = 16'd512;
        for (int h = 0; h < NHID; h++) begin
            currW0[h][0] = 16'd256; currW0[h][1] = 16'd0; currb0[h] = 16'd0;
        end
        for (int o = 0; o < NOUT; o++) begin
            currb1[o] = 16'd0;
            for (int j = 0; j < NHID; j++) currW1[o][j] = (o == 1) ? 16'd256 : 16'd0;
        end
        expL[0] = 16'd0; expL[1] = 16'd2048; expL[2] = 16'd0;
        launch();
        for (int n = 1; n <= 42; n++) begin
            if (n > 1) @(negedge clk);
            checks++; if (busy !== 1'(n <= 41)) begin errors++; $display("[TB] FAIL latency_busy@%0d: got %b expected %b", n, busy, n <= 41); end
            checks++; if (done !== 1'(n == 42)) begin errors++; $display("[TB] FAIL latency_done@%0d: got %b expected %b", n, done, n == 42); end
            if (n == 20 || n == 41) begin
                checks++; if (reluout !== '0) begin errors++; $display("[TB] FAIL partial_reluout@%0d: got %h expected 0", n, reluout); end
            end
        end
        for (int h = 0; h < NHID; h++) begin
            checks++; if (reluout[h] !== 16'd256) begin errors++; $display("[TB] FAIL directed_relu[%0d]: got %0d expected 256", h, reluout[h]); end
        end
        for (int o = 0; o < NOUT; o++) begin
            checks++; if (logits[o] !== expL[o]) begin errors++; $display("[TB] FAIL directed_logit[%0d]: got %0d expected %0d", o, $signed(logits[o]), $signed(expL[o])); end
        end
        checks++; if (predictedstate !== 2'd1) begin errors++; $display("[TB] FAIL directed_pred: got %0d expected 1", predictedstate); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width: got %b expected 0", done); end
    endtask

    task automatic test_negative();
        int lat;
        logic [NOUT-1:0][DW-1:0] expL;
        for (int h = 0; h < NHID; h++) begin
            currW0[h][0] = 16'hFF00; currW0[h][1] = 16'd0; currb0[h] = 16'd0;
        end
        currb1[0] = 16'd10; currb1[1] = 16'd20; currb1[2] = 16'd5;
        expL = {16'd5, 16'd20, 16'd10};
        launch();
        waitDone(lat);
        checks++; if (lat !== 42) begin errors++; $display("[TB] FAIL negative_latency: got %0d expected 42", lat); end
        for (int h = 0; h < NHID; h++) begin
            checks++; if (reluout[h] !== 16'd0) begin errors++; $display("[TB] FAIL negative_relu[%0d]: got %0d expected 0", h, reluout[h]); end
        end
        for (int o = 0; o < NOUT; o++) begin
            checks++; if (logits[o] !== expL[o]) begin errors++; $display("[TB] FAIL negative_logit[%0d]: got %0d expected %0d", o, $signed(logits[o]), expL[o]); end
        end
        checks++; if (predictedstate !== 2'd1) begin errors++; $display("[TB] FAIL negative_pred: got %0d expected 1", predictedstate); end
    endtask

    task automatic test_tie();
        int lat;
        for (int h = 0; h < NHID; h++) begin
            currW0[h][0] = 16'd256; currW0[h][1] = 16'd0; currb0[h] = 16'd0;
        end
        currW1 = '0;
        for (int o = 0; o < NOUT; o++) currb1[o] = 16'd7;
        launch();
        waitDone(lat);
        checks++; if (lat !== 42) begin errors++; $display("[TB] FAIL tie_latency: got %0d expected 42", lat); end
        for (int o = 0; o < NOUT; o++) begin
            checks++; if (logits[o] !== 16'd7) begin errors++; $display("[TB] FAIL tie_logit[%0d]: got %0d expected 7", o, $signed(logits[o])); end
        end
        checks++; if (predictedstate !== 2'd0) begin errors++; $display("[TB] FAIL tie_pred: got %0d expected 0", predictedstate); end
    endtask

    task automatic test_saturate();
        int lat;
        inputs[0] = 16'd32767;
        inputs[1] = 16'd32767;
        for (int h = 0; h < NHID; h++) begin
            currW0[h][0] = 16'd32767; currW0[h][1] = 16'd32767; currb0[h] = 16'd32767;
        end
        launch();
        waitDone(lat);
        checks++; if (lat !== 42) begin errors++; $display("[TB] FAIL saturate_latency: got %0d expected 42", lat); end
        for (int h = 0; h < NHID; h++) begin
            checks++; if (reluout[h] !== 16'd32767) begin errors++; $display("[TB] FAIL saturate_relu[%0d]: got %0d expected 32767", h, reluout[h]); end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 15; t++) begin
            applyStimulus();
            launch();
            buildModel();
            // Inputs change after being captured; the pass must ignore this
            for (int j = 0; j < NIN; j++) inputs[j] = randVal();
            waitDone(lat);
            checks++; if (lat !== 42) begin errors++; $display("[TB] FAIL random%0d_latency: got %0d expected 42", t, lat); end
            for (int h = 0; h < NHID; h++) begin
                checks++; if (reluout[h] !== expRelu[h]) begin errors++; $display("[TB] FAIL random%0d_relu[%0d]: got %0d expected %0d", t, h, reluout[h], expRelu[h]); end
            end
            for (int o = 0; o < NOUT; o++) begin
                checks++; if (logits[o] !== expLogits[o]) begin errors++; $display("[TB] FAIL random%0d_logit[%0d]: got %0d expected %0d", t, o, $signed(logits[o]), $signed(expLogits[o])); end
            end
            checks++; if (predictedstate !== expPred) begin errors++; $display("[TB] FAIL random%0d_pred: got %0d expected %0d", t, predictedstate, expPred); end
        end
    endtask

    task automatic test_reset_midpass();
        int lat;
        applyStimulus();
        launch();
        for (int n = 1; n <= 25; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 20) rst = 1'b1;
            if (n == 21) begin
                rst = 1'b0;
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
                checks++; if (reluout !== '0) begin errors++; $display("[TB] FAIL midreset_reluout: got %h expected 0", reluout); end
                checks++; if (logits !== '0) begin errors++; $display("[TB] FAIL midreset_logits: got %h expected 0", logits); end
                checks++; if (predictedstate !== 2'd0) begin errors++; $display("[TB] FAIL midreset_pred: got %0d expected 0", predictedstate); end
            end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_nodone@%0d: got %b expected 0", n, done); end
            if (n == 25) begin
                start  = 1'b1;
                modelX = inputs;
            end
        end
        @(negedge clk);
        start = 1'b0;
        buildModel();
        waitDone(lat);
        checks++; if (lat !== 42) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected 42", lat); end
        for (int h = 0; h < NHID; h++) begin
            checks++; if (reluout[h] !== expRelu[h]) begin errors++; $display("[TB] FAIL midreset_relu[%0d]: got %0d expected %0d", h, reluout[h], expRelu[h]); end
        end
        for (int o = 0; o < NOUT; o++) begin
            checks++; if (logits[o] !== expLogits[o]) begin errors++; $display("[TB] FAIL midreset_logit[%0d]: got %0d expected %0d", o, $signed(logits[o]), $signed(expLogits[o])); end
        end
        checks++; if (predictedstate !== expPred) begin errors++; $display("[TB] FAIL midreset_pred_after: got %0d expected %0d", predictedstate, expPred); end
    endtask

    task automatic test_back_to_back();
        int n;
        int last;
        int count;
        applyStimulus();
        @(negedge clk);
        start  = 1'b1;
        modelX = inputs;
        buildModel();
        n = 0; last = 0; count = 0;
        while (count < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                if (count == 0) begin
                    checks++; if (n !== 42) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 42", n); end
                end else begin
                    checks++; if (n - last !== 43) begin errors++; $display("[TB] FAIL b2b_period%0d: got %0d expected 43", count, n - last); end
                end
                for (int o = 0; o < NOUT; o++) begin
                    checks++; if (logits[o] !== expLogits[o]) begin errors++; $display("[TB] FAIL b2b_logit[%0d]: got %0d expected %0d", o, $signed(logits[o]), $signed(expLogits[o])); end
                end
                checks++; if (predictedstate !== expPred) begin errors++; $display("[TB] FAIL b2b_pred: got %0d expected %0d", predictedstate, expPred); end
                last = n;
                count++;
            end
        end
        start = 1'b0;
        checks++; if (count !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", count); end
    endtask

    task automatic test_start_ignored();
        int count;
        int doneAt;
        applyStimulus();
        launch();
        buildModel();
        count = 0; doneAt = 0;
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
            if (done === 1'b1) begin
                count++;
                doneAt = n;
            end
        end
        checks++; if (count !== 1) begin errors++; $display("[TB] FAIL ignored_count: got %0d expected 1", count); end
        checks++; if (doneAt !== 42) begin errors++; $display("[TB] FAIL ignored_doneAt: got %0d expected 42", doneAt); end
        checks++; if (predictedstate !== expPred) begin errors++; $display("[TB] FAIL ignored_pred: got %0d expected %0d", predictedstate, expPred); end
    endtask

    initial begin
        test_reset();
        test_directed_latency();
        test_negative();
        test_tie();
        test_saturate();
        test_random();
        test_reset_midpass();
        test_back_to_back();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forwardprop.md
FORWARDPROP -- requirements
Module: forwardprop

Interface
REQ-001 Parameter DATAWIDTH, default 16: width of all signed two's-complement fixed-point data ports.
REQ-002 Parameter FRACBITS, default 8: fractional bits, so 1.0 = 2^FRACBITS.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request one forward pass; sampled only in IDLE.
REQ-006 inputs  in  [DATAWIDTH-1:0] x2  network input vector x.
REQ-007 currW0  in  [DATAWIDTH-1:0] x8x2; currb0  in  [DATAWIDTH-1:0] x8: hidden-layer weights/bias; held stable while busy.
REQ-008 currW1  in  [DATAWIDTH-1:0] x3x8; currb1  in  [DATAWIDTH-1:0] x3: output-layer weights/bias; held stable while busy.
REQ-009 busy  out  1  pass in progress.
REQ-010 done  out  1  one-cycle pulse: results valid.
REQ-011 reluout  out  [DATAWIDTH-1:0] x8  hidden activations A0 = relu(W0*x+b0).
REQ-012 logits  out  [DATAWIDTH-1:0] x3  Z1 = W1*A0+b1 (softmax input).
REQ-013 predictedstate  out  2  argmax of logits, 0..2.

Function
REQ-014 States: IDLE, HID, OUT, ARG, DONE; IDLE->HID when start=1; HID->OUT after 16 cycles; OUT->ARG after 24 cycles; ARG->DONE; DONE->IDLE unconditionally.
REQ-015 HID: one MAC per cycle, neuron h=0..7, 2 cycles each; cycle 1 acc = b0[h] + W0[h][0]*x0, cycle 2 acc += W0[h][1]*x1, then A0[h] = relu(sat(acc)) into a working register.
REQ-016 OUT: neuron o=0..2, 8 cycles each; cycle 1 acc = b1[o] + W1[o][0]*A0[0], cycles 2..8 add W1[o][j]*A0[j]; Z1[o] = sat(acc).
REQ-017 Each product is full 2*DATAWIDTH signed, arithmetic-shifted right by FRACBITS (truncate toward -inf) before accumulation.
REQ-018 Accumulator is DATAWIDTH+4 bits signed; on write-back saturate to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
REQ-019 ARG: predictedstate = index of largest signed Z1; ties resolve to lowest index.
REQ-020 Latency: start sampled at edge k -> busy=1 cycles k+1..k+41, done=1 during cycle k+42 only, busy=0 while done=1.
REQ-021 reluout, logits, predictedstate are loaded from working registers on entry to DONE and hold until the next DONE; they never show partial results.
REQ-022 start while not IDLE is ignored; start held high gives back-to-back passes, done period 43 cycles.
REQ-023 inputs are latched at the IDLE->HID transition; later changes do not affect the pass.

Reset
REQ-024 rst=1 at any edge: state=IDLE, busy=0, done=0, reluout=0, logits=0, predictedstate=0, accumulator and working registers=0.
REQ-025 rst mid-pass aborts it; no done is produced for the aborted pass; a start after rst release runs a normal pass.

Structure
REQ-026 Shared package mlp_pkg holds NIN=2, NHID=8, NOUT=3, the state enum and the 2-bit state index type; backprop uses the same package.
REQ-027 One sub-module mac_sat: signed multiply, FRACBITS shift, accumulate, saturate; instantiated once and time-shared.

Verification (DATAWIDTH=16, FRACBITS=8)
REQ-028 x=(256,512), W0[h]=(256,0), b0=0, W1 row1 all 256, other rows 0, b1=0 -> reluout all 256, logits=(0,2048,0), predictedstate=1, done at k+42.
REQ-029 W0[h]=(-256,0), b0=0, b1=(10,20,5) -> reluout all 0, logits=(10,20,5), predictedstate=1.
REQ-030 W1=0, b1=(7,7,7) -> logits=(7,7,7), predictedstate=0 (tie to lowest index).
REQ-031 x=(32767,32767), W0=32767, b0=32767 -> reluout all 32767 (saturated, no wrap).
REQ-032 rst pulsed at k+20 -> busy=0 and outputs 0 from k+21, no done; start at k+25 -> done at k+67 with correct results.
REQ-033 start held high continuously -> done pulses exactly 43 cycles apart; start pulse at k+10 during busy -> no extra pass.
